rgb_rank_classifier: RTL and testbench
======================================

Name: rgb_rank_classifier

Overview:
- Parametrised successor to the fixed 16-block RGB sorter in the camera colour-classification path.
- Accepts N blocks of NCH colour channels and ranks every channel independently with a stable odd-even transposition sort.
- Buckets each block's per-channel rank against run-time thresholds and emits a per-block label.
- Feeds the board-state decoder with one label per tile.

Parameters:
- N, 16, number of blocks; 2..32.
- CH_W, 8, bits per channel sample.
- NCH, 3, channels per block; 1..4. Channel 0 is B, 1 is G, 2 is R.
- IDX_W, $clog2(N), rank width. Derived; do not override.
- LBL_W, 2*NCH, label width. Derived.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_start  in  1  start request; sampled only in S_IDLE.
- i_data  in  N*NCH*CH_W  samples; block j, channel c at [(j*NCH+c)*CH_W +: CH_W].
- i_thr_lo  in  NCH*(IDX_W+1)  per-channel low threshold, channel c at [c*(IDX_W+1) +: IDX_W+1].
- i_thr_hi  in  NCH*(IDX_W+1)  per-channel high threshold, same packing.
- o_busy  out  1  high in every state except S_IDLE.
- o_done  out  1  one-cycle pulse; o_rank and o_label are valid from this cycle.
- o_rank  out  N*NCH*IDX_W  rank of block j, channel c at [(j*NCH+c)*IDX_W +: IDX_W]; 0 = smallest.
- o_label  out  N*LBL_W  label of block j at [j*LBL_W +: LBL_W]; bits [2c+1:2c] are the bucket of channel c.

Behaviour:
- Reset: state S_IDLE; o_busy=0, o_done=0, o_rank=0, o_label=0. All internal value, index and rank arrays and the pass counter are cleared.
- Reset asserted at any point, including mid-sort, aborts the run immediately. No partial result is ever written to the outputs.
- S_IDLE with i_start=1: on the sampling edge, load i_data into the per-channel value arrays and set index[c][k]=k. Latch i_thr_lo and i_thr_hi. Clear pass counter p. Go to S_SORT.
- S_SORT runs exactly N cycles, p = 0..N-1, all channels in parallel.
  - Even p: compare positions (0,1), (2,3), ...
  - Odd p: compare positions (1,2), (3,4), ...
  - A pair swaps value and index only if left > right (strict). Equal values never swap, so the sort is stable.
  - After p = N-1, go to S_RANK.
- S_RANK (1 cycle): for each channel c and position k, set rank[c][index[c][k]] = k.
- S_LABEL (1 cycle): for each channel, bucket = 0 if rank < thr_lo; else 1 if rank < thr_hi; else 2. Code 3 is never produced.
  - If thr_lo >= thr_hi, bucket 1 is empty.
  - A threshold >= N places every block in the lower bucket.
  - o_rank and o_label are written on this edge only. Otherwise they hold the previous run's values, including throughout a new run.
- S_DONE (1 cycle): o_done=1; return to S_IDLE.
- Latency: o_done rises N+2 rising edges after the edge that samples i_start; for N=16 that is edge 18. o_done is low in all other states.
- i_start while o_busy=1 is ignored and not queued. If i_start is still high when back in S_IDLE, a new run starts on that edge.
- Comparisons are unsigned over CH_W bits.
- Ranks form a permutation of 0..N-1 in every channel.

Test Plan (N=16, CH_W=8, NCH=3, all thresholds lo=6, hi=10 unless stated):
- Reset: hold i_rst_n=0, then release -> o_busy=0, o_done=0, o_rank=0, o_label=0; no activity until i_start.
- Ascending input, all channels of block j = 10*j; pulse i_start at edge 0 -> o_done high only after edge 18.
  - Every rank[j][c] = j.
  - Label j=0 is 6'b000000, j=7 is 6'b010101, j=15 is 6'b101010.
- Descending input, block j = 255-j -> rank j = 15-j; label j=0 is 6'b101010, j=15 is 6'b000000.
- All samples = 8'h80 -> stability: rank j = j in every channel. Thresholds lo=10, hi=4 -> labels j<10 are 6'b000000, j>=10 are 6'b101010.
- Mixed channels: R ascending, G descending, B all equal, lo=hi=8.
  - Block 3 label: R bucket 0, G bucket 2, B bucket 0 = 6'b001000.
  - Hold i_start high through the run -> it is ignored while busy; a second run starts the cycle after o_done.
- Reset mid-run: assert i_rst_n=0 at sort pass 5 -> o_busy=0 and outputs zero; no o_done. A fresh start afterwards completes with correct ranks.

Source files
------------

// File: rtl/rgb_rank_classifier.sv
// Ranks every colour channel of N blocks with a stable odd-even transposition sort,
// then buckets each per-channel rank against run-time thresholds into a per-block label.
module rgb_rank_classifier #(
  parameter int unsigned N     = 16,
  parameter int unsigned CH_W  = 8,
  parameter int unsigned NCH   = 3,
  parameter int unsigned IDX_W = $clog2(N),
  parameter int unsigned LBL_W = 2 * NCH
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_start,
  input  logic [N*NCH*CH_W-1:0]       i_data,
  input  logic [NCH*(IDX_W+1)-1:0]    i_thr_lo,
  input  logic [NCH*(IDX_W+1)-1:0]    i_thr_hi,
  output logic                        o_busy,
  output logic                        o_done,
  output logic [N*NCH*IDX_W-1:0]      o_rank,
  output logic [N*LBL_W-1:0]          o_label
);

  localparam int unsigned TW = IDX_W + 1;
  localparam logic [IDX_W-1:0] LastPass = IDX_W'(N - 1);

  typedef enum logic [2:0] {StIdle, StSort, StRank, StLabel, StDone} state_e;

  state_e state_q, state_d;

  logic [CH_W-1:0]     val_q  [NCH][N];
  logic [CH_W-1:0]     val_d  [NCH][N];
  logic [IDX_W-1:0]    idx_q  [NCH][N];
  logic [IDX_W-1:0]    idx_d  [NCH][N];
  logic [IDX_W-1:0]    rank_q [NCH][N];
  logic [IDX_W-1:0]    rank_d [NCH][N];
  logic [IDX_W-1:0]    pass_q;
  logic [NCH*TW-1:0]   thr_lo_q, thr_hi_q;
  logic [N*NCH*IDX_W-1:0] rank_flat, rank_out_q;
  logic [N*LBL_W-1:0]  label_d, label_out_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (i_start) state_d = StSort;
      StSort:  if (pass_q == LastPass) state_d = StRank;
      StRank:  state_d = StLabel;
      StLabel: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // One transposition pass; pairs within a pass are disjoint, so all swaps read the old array.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      for (int k = 0; k < N; k++) begin
        val_d[c][k] = val_q[c][k];
        idx_d[c][k] = idx_q[c][k];
      end
    end
    for (int c = 0; c < NCH; c++) begin
      for (int k = 0; k < N - 1; k++) begin
        if (((k % 2) == int'(pass_q[0])) && (val_q[c][k] > val_q[c][k+1])) begin
          val_d[c][k]   = val_q[c][k+1];
          val_d[c][k+1] = val_q[c][k];
          idx_d[c][k]   = idx_q[c][k+1];
          idx_d[c][k+1] = idx_q[c][k];
        end
      end
    end
  end

  // Invert the sorted index permutation into per-block ranks.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      for (int k = 0; k < N; k++) rank_d[c][k] = '0;
    end
    for (int c = 0; c < NCH; c++) begin
      for (int k = 0; k < N; k++) rank_d[c][idx_q[c][k]] = IDX_W'(k);
    end
  end

  always_comb begin
    rank_flat = '0;
    label_d   = '0;
    for (int j = 0; j < N; j++) begin
      for (int c = 0; c < NCH; c++) begin
        rank_flat[(j*NCH+c)*IDX_W +: IDX_W] = rank_q[c][j];
        if ({1'b0, rank_q[c][j]} < thr_lo_q[c*TW +: TW]) begin
          label_d[j*LBL_W + 2*c +: 2] = 2'd0;
        end else if ({1'b0, rank_q[c][j]} < thr_hi_q[c*TW +: TW]) begin
          label_d[j*LBL_W + 2*c +: 2] = 2'd1;
        end else begin
          label_d[j*LBL_W + 2*c +: 2] = 2'd2;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        for (int k = 0; k < N; k++) begin
          val_q[c][k]  <= '0;
          idx_q[c][k]  <= '0;
          rank_q[c][k] <= '0;
        end
      end
      pass_q      <= '0;
      thr_lo_q    <= '0;
      thr_hi_q    <= '0;
      rank_out_q  <= '0;
      label_out_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            for (int c = 0; c < NCH; c++) begin
              for (int k = 0; k < N; k++) begin
                val_q[c][k] <= i_data[(k*NCH+c)*CH_W +: CH_W];
                idx_q[c][k] <= IDX_W'(k);
              end
            end
            thr_lo_q <= i_thr_lo;
            thr_hi_q <= i_thr_hi;
            pass_q   <= '0;
          end
        end
        StSort: begin
          val_q  <= val_d;
          idx_q  <= idx_d;
          pass_q <= pass_q + 1'b1;
        end
        StRank:  rank_q <= rank_d;
        StLabel: begin
          rank_out_q  <= rank_flat;
          label_out_q <= label_d;
        end
        default: ;
      endcase
    end
  end

  assign o_busy  = (state_q != StIdle);
  assign o_done  = (state_q == StDone);
  assign o_rank  = rank_out_q;
  assign o_label = label_out_q;

endmodule

// File: tb/tb_rgb_rank_classifier.sv
// Directed bench for rgb_rank_classifier at N=16, CH_W=8, NCH=3.
module tb_rgb_rank_classifier;

  localparam int N = 16;
  localparam int CH_W = 8;
  localparam int NCH = 3;
  localparam int IDX_W = 4;
  localparam int TW = IDX_W + 1;
  localparam int LBL_W = 2 * NCH;

  logic                     i_clk = 1'b0;
  logic                     i_rst_n = 1'b0;
  logic                     i_start = 1'b0;
  logic [N*NCH*CH_W-1:0]    i_data = '0;
  logic [NCH*TW-1:0]        i_thr_lo = '0;
  logic [NCH*TW-1:0]        i_thr_hi = '0;
  logic                     o_busy, o_done;
  logic [N*NCH*IDX_W-1:0]   o_rank;
  logic [N*LBL_W-1:0]       o_label;

  int n_checks = 0;
  int n_fail = 0;

  rgb_rank_classifier #(.N(N), .CH_W(CH_W), .NCH(NCH)) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_start  (i_start),
    .i_data   (i_data),
    .i_thr_lo (i_thr_lo),
    .i_thr_hi (i_thr_hi),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_rank   (o_rank),
    .o_label  (o_label)
  );

  always #5 i_clk = ~i_clk;

  task automatic set_thr(input int lo, input int hi);
    for (int c = 0; c < NCH; c++) begin
      i_thr_lo[c*TW +: TW] = TW'(lo);
      i_thr_hi[c*TW +: TW] = TW'(hi);
    end
  endtask

  task automatic set_sample(input int j, input int c, input int v);
    i_data[(j*NCH+c)*CH_W +: CH_W] = CH_W'(v);
  endtask

  // Edge 0 samples i_start; returns the edge number on which o_done was seen (0 on timeout).
  task automatic run(input bit hold, output int edge_n);
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    if (!hold) i_start = 1'b0;
    edge_n = 0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge i_clk);
      #1;
      if (o_done) begin
        edge_n = e;
        break;
      end
    end
  endtask

  function automatic int rank_of(input int j, input int c);
    return int'(o_rank[(j*NCH+c)*IDX_W +: IDX_W]);
  endfunction

  task automatic test_reset;
    i_rst_n = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge i_clk);
      #1;
      n_checks++;
      if (o_busy !== 1'b0 || o_done !== 1'b0 || o_rank !== '0 || o_label !== '0) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: busy=%b done=%b rank=%h label=%h, required all zero",
                 i, o_busy, o_done, o_rank, o_label);
      end
    end
  endtask

  task automatic test_ascending;
    int e;
    int bad;
    for (int j = 0; j < N; j++) for (int c = 0; c < NCH; c++) set_sample(j, c, 10 * j);
    set_thr(6, 10);
    run(1'b0, e);
    n_checks++;
    if (e !== 18) begin
      n_fail++;
      $display("FAIL asc_latency: done at edge %0d, required 18", e);
    end
    bad = 0;
    for (int j = 0; j < N; j++) for (int c = 0; c < NCH; c++) if (rank_of(j, c) != j) bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL asc_ranks: %0d wrong ranks, required rank[j]=j (o_rank=%h)", bad, o_rank);
    end
    n_checks++;
    if (o_label[0*LBL_W +: LBL_W] !== 6'b000000) begin
      n_fail++;
      $display("FAIL asc_label0: got %b, required 000000", o_label[0 +: LBL_W]);
    end
    n_checks++;
    if (o_label[7*LBL_W +: LBL_W] !== 6'b010101) begin
      n_fail++;
      $display("FAIL asc_label7: got %b, required 010101", o_label[7*LBL_W +: LBL_W]);
    end
    n_checks++;
    if (o_label[15*LBL_W +: LBL_W] !== 6'b101010) begin
      n_fail++;
      $display("FAIL asc_label15: got %b, required 101010", o_label[15*LBL_W +: LBL_W]);
    end
    @(posedge i_clk);
    #1;
    n_checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL asc_after_done: done=%b busy=%b, required 0 0", o_done, o_busy);
    end
  endtask

  task automatic test_descending;
    int e;
    int bad;
    for (int j = 0; j < N; j++) for (int c = 0; c < NCH; c++) set_sample(j, c, 255 - j);
    set_thr(6, 10);
    run(1'b0, e);
    bad = 0;
    for (int j = 0; j < N; j++) for (int c = 0; c < NCH; c++) if (rank_of(j, c) != 15 - j) bad++;
    n_checks++;
    if (e !== 18 || bad != 0) begin
      n_fail++;
      $display("FAIL desc_ranks: edge %0d, %0d wrong ranks; required edge 18, rank=15-j", e, bad);
    end
    n_checks++;
    if (o_label[0 +: LBL_W] !== 6'b101010 || o_label[15*LBL_W +: LBL_W] !== 6'b000000) begin
      n_fail++;
      $display("FAIL desc_labels: j0=%b j15=%b, required 101010 000000",
               o_label[0 +: LBL_W], o_label[15*LBL_W +: LBL_W]);
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_equal;
    int e;
    int bad;
    int bad_lbl;
    logic [LBL_W-1:0] exp_lbl;
    for (int j = 0; j < N; j++) for (int c = 0; c < NCH; c++) set_sample(j, c, 8'h80);
    set_thr(10, 4);
    run(1'b0, e);
    bad = 0;
    bad_lbl = 0;
    for (int j = 0; j < N; j++) begin
      for (int c = 0; c < NCH; c++) if (rank_of(j, c) != j) bad++;
      exp_lbl = (j < 10) ? 6'b000000 : 6'b101010;
      if (o_label[j*LBL_W +: LBL_W] !== exp_lbl) bad_lbl++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL equal_stable: %0d ranks differ from j (o_rank=%h)", bad, o_rank);
    end
    n_checks++;
    if (bad_lbl != 0) begin
      n_fail++;
      $display("FAIL equal_labels_lo_ge_hi: %0d wrong labels (o_label=%h)", bad_lbl, o_label);
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_back_to_back;
    int e;
    int e2;
    logic [N*LBL_W-1:0] first_label;
    for (int j = 0; j < N; j++) begin
      set_sample(j, 2, 10 * j);
      set_sample(j, 1, 255 - j);
      set_sample(j, 0, 8'h80);
    end
    set_thr(8, 8);
    run(1'b1, e);
    n_checks++;
    if (e !== 18) begin
      n_fail++;
      $display("FAIL mixed_latency_held_start: done at edge %0d, required 18", e);
    end
    n_checks++;
    if (o_label[3*LBL_W +: LBL_W] !== 6'b001000) begin
      n_fail++;
      $display("FAIL mixed_label3: got %b, required 001000", o_label[3*LBL_W +: LBL_W]);
    end
    n_checks++;
    if (rank_of(3, 2) != 3 || rank_of(3, 1) != 12 || rank_of(3, 0) != 3) begin
      n_fail++;
      $display("FAIL mixed_rank3: R=%0d G=%0d B=%0d, required 3 12 3",
               rank_of(3, 2), rank_of(3, 1), rank_of(3, 0));
    end
    first_label = o_label;
    @(posedge i_clk);
    #1;
    n_checks++;
    if (o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle_gap: busy=%b, required 0", o_busy);
    end
    // Start still high here, so the next edge launches the second run.
    for (int j = 0; j < N; j++) for (int c = 0; c < NCH; c++) set_sample(j, c, 255 - j);
    set_thr(6, 10);
    run(1'b0, e2);
    n_checks++;
    if (e2 !== 18) begin
      n_fail++;
      $display("FAIL b2b_second_run: done at edge %0d, required 18", e2);
    end
    n_checks++;
    if (o_label[3*LBL_W +: LBL_W] !== 6'b101010 || first_label === o_label) begin
      n_fail++;
      $display("FAIL b2b_second_label3: got %b, required 101010", o_label[3*LBL_W +: LBL_W]);
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_hold_during_run;
    logic [N*LBL_W-1:0] prev_label;
    logic [N*NCH*IDX_W-1:0] prev_rank;
    prev_label = o_label;
    prev_rank = o_rank;
    for (int j = 0; j < N; j++) for (int c = 0; c < NCH; c++) set_sample(j, c, 10 * j);
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    repeat (10) @(posedge i_clk);
    #1;
    n_checks++;
    if (o_busy !== 1'b1 || o_rank !== prev_rank || o_label !== prev_label) begin
      n_fail++;
      $display("FAIL hold_outputs_mid_run: busy=%b rank=%h label=%h, required 1 and previous values",
               o_busy, o_rank, o_label);
    end
    repeat (12) @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset_mid_run;
    int e;
    int bad;
    bit saw_done;
    for (int j = 0; j < N; j++) for (int c = 0; c < NCH; c++) set_sample(j, c, 10 * j);
    set_thr(6, 10);
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    repeat (5) @(posedge i_clk);
    #1;
    i_rst_n = 1'b0;
    #1;
    n_checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_rank !== '0 || o_label !== '0) begin
      n_fail++;
      $display("FAIL midrun_reset: busy=%b done=%b rank=%h label=%h, required all zero",
               o_busy, o_done, o_rank, o_label);
    end
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge i_clk);
      #1;
      if (o_done || o_busy) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done) begin
      n_fail++;
      $display("FAIL midrun_no_done: activity seen after aborted run, required none");
    end
    for (int j = 0; j < N; j++) for (int c = 0; c < NCH; c++) set_sample(j, c, 255 - j);
    run(1'b0, e);
    bad = 0;
    for (int j = 0; j < N; j++) for (int c = 0; c < NCH; c++) if (rank_of(j, c) != 15 - j) bad++;
    n_checks++;
    if (e !== 18 || bad != 0) begin
      n_fail++;
      $display("FAIL midrun_fresh_start: edge %0d, %0d wrong ranks; required edge 18, rank=15-j",
               e, bad);
    end
  endtask

  initial begin
    test_reset();
    test_ascending();
    test_descending();
    test_equal();
    test_back_to_back();
    test_hold_during_run();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
